// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the wide add/subtract sequencer.
//   WORD_W  : width of the time-multiplexed adder slice
//   state_t : sequencer state encoding
package wide_add_seq_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/rca_16b.sv
// 16-bit adder slice with carry in/out.
// Ports:
//   a, b        : 16-bit addends
//   ci          : carry into bit 0
//   sum         : 16-bit sum
//   co          : carry out of bit 15
//   last_bit_ci : carry into bit 15 (used for signed overflow detection)
module rca_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] sum,
    output logic        co,
    output logic        last_bit_ci
);

    logic [15:0] low;
    logic        c15;

    // The low 15 bits are added on their own so the carry into the top bit
    // is visible for overflow detection.
    assign low         = {1'b0, a[14:0]} + {1'b0, b[14:0]} + {15'd0, ci};
    assign c15         = low[15];
    assign sum         = {a[15] ^ b[15] ^ c15, low[14:0]};
    assign co          = (a[15] & b[15]) | (c15 & (a[15] ^ b[15]));
    assign last_bit_ci = c15;

endmodule

// File: rtl/wide_add_seq.sv
// Wide add/subtract sequencer: one 16-bit slice reused once per word,
// least-significant word first, carry registered between words.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for operands, in_ready high
//   RUN    | one word per cycle through the slice
//   DONE   | result presented, out_valid high until out_ready
//
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake
//   a, b, c_in, sub       : operands, carry-in (add only), 1 = A-B
//   out_valid / out_ready : result handshake
//   sum, c_out, overflow  : result, carry out of MSB, signed overflow
//   busy                  : high while in RUN or DONE
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int NUM_WORDS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0]   a,
    input  logic [WORD_W*NUM_WORDS-1:0]   b,
    input  logic                          c_in,
    input  logic                          sub,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W*NUM_WORDS-1:0]   sum,
    output logic                          c_out,
    output logic                          overflow,
    output logic                          busy
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t state, state_nxt;

    logic [NUM_WORDS-1:0][WORD_W-1:0] op_a;
    logic [NUM_WORDS-1:0][WORD_W-1:0] op_b;
    logic [NUM_WORDS-1:0][WORD_W-1:0] sum_r;
    logic [IDX_W-1:0]                 idx;
    logic                             carry;
    logic                             c_out_r;
    logic                             overflow_r;

    logic [WORD_W-1:0] slice_sum;
    logic              slice_co;
    logic              slice_lci;
    logic              last_word;

    rca_16b u_slice (
        .a           (op_a[idx]),
        .b           (op_b[idx]),
        .ci          (carry),
        .sum         (slice_sum),
        .co          (slice_co),
        .last_bit_ci (slice_lci)
    );

    assign last_word = (idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_word) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            sum_r      <= '0;
            idx        <= '0;
            carry      <= 1'b0;
            c_out_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1; c_in is ignored.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub | c_in;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    sum_r[idx] <= slice_sum;
                    carry      <= slice_co;
                    if (last_word) begin
                        c_out_r    <= slice_co;
                        overflow_r <= slice_co ^ slice_lci;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum      = sum_r;
    assign c_out    = c_out_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_wide_add_seq.sv
module tb_wide_add_seq;

    localparam int NW = 4;
    localparam int W  = 16 * NW;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;
    logic         busy;

    always #5 clock = ~clock;

    wide_add_seq #(.NUM_WORDS(NW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain wide arithmetic; signed overflow from operand/result signs.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rc, input logic rs);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ov;
        bb   = rs ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, (rs | rc)};
        ov   = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
        return {ov, full};
    endfunction

    typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
    mph_t         m_ph = M_IDLE;
    int           m_left;
    bit           m_live = 1'b0;
    logic [W-1:0] m_sum, p_sum;
    logic         m_co, m_ov, p_co, p_ov;

    // Protocol-level model: NW busy cycles per op, result appears at the end.
    always @(posedge clock) begin
        if (reset) begin
            m_ph   = M_IDLE;
            m_sum  = '0;
            m_co   = 1'b0;
            m_ov   = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            case (m_ph)
                M_IDLE: if (in_valid) begin
                    {p_ov, p_co, p_sum} = ref_op(a, b, c_in, sub);
                    m_left = NW;
                    m_ph   = M_RUN;
                end
                M_RUN: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ph  = M_DONE;
                        m_sum = p_sum;
                        m_co  = p_co;
                        m_ov  = p_ov;
                    end
                end
                M_DONE: if (out_ready) m_ph = M_IDLE;
                default: m_ph = M_IDLE;
            endcase
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            chk("in_ready",  in_ready,  m_ph == M_IDLE);
            chk("out_valid", out_valid, m_ph == M_DONE);
            chk("busy",      busy,      m_ph != M_IDLE);
            if (m_ph != M_RUN) begin
                chk("sum",      sum,      m_sum);
                chk("c_out",    c_out,    m_co);
                chk("overflow", overflow, m_ov);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
        int n;
        a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin step(); n++; end
        if (!in_ready) chk("accept_timeout", 0, 1);
        step();
        in_valid = 1'b0;
        // Scramble inputs after acceptance; the op must use captured values.
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        c_in = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin step(); lat++; end
        if (!out_valid) chk("done_timeout", 0, 1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc, input logic ts, input logic [W-1:0] es,
                            input logic eco, input logic eov);
        int lat;
        start_op(ta, tb_, tc, ts);
        wait_done(lat);
        chk({name, "_latency"}, lat, 4);
        chk({name, "_sum"}, sum, es);
        chk({name, "_c_out"}, c_out, eco);
        chk({name, "_overflow"}, overflow, eov);
        release_out();
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 3))
            0: return {W{1'b1}};
            1: return W'($urandom_range(0, 15));
            2: return {1'b0, {(W-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int lat;
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_sum",       sum,       0);
        reset = 1'b0;
        step();

        directed("carry_word0", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
                 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        directed("carry_all",   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                 64'h0, 1'b1, 1'b0);
        directed("signed_ovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        directed("sub_borrow",  64'h5, 64'h7, 1'b1, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        directed("sub_noborrow", 64'h7, 64'h5, 1'b0, 1'b1,
                 64'h2, 1'b1, 1'b0);

        // Backpressure: result must hold while a new request waits.
        start_op(64'h1234, 64'h1111, 1'b0, 1'b0);
        wait_done(lat);
        a = 64'h10; b = 64'h20; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready",  in_ready,  0);
            chk("bp_sum",       sum,       64'h2345);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        wait_done(lat);
        chk("bp_new_latency", lat, 4);
        chk("bp_new_sum", sum, 64'h30);
        release_out();

        // Reset in the middle of RUN discards the op.
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_in_ready",  in_ready,  1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy",      busy,      0);
        chk("midrst_sum",       sum,       0);
        directed("after_rst", 64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0);

        // Random ops with stray in_valid/out_ready and random consumer delay.
        for (int k = 0; k < 40; k++) begin
            out_ready = 1'($urandom);
            start_op(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
            lat = 0;
            while (!out_valid && lat < 100) begin
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
                step();
                lat++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk("rnd_latency", lat, 4);
            repeat ($urandom_range(0, 3)) step();
            release_out();
        end

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
